// File: rtl/cc_neuron_accumulator.sv
// Neuron accumulator: sums NUMBER_INPUTS unsigned x*w products, then
// scales and clamps the sum into a registered result for the comparator.
module cc_neuron_accumulator #(
    parameter int NUMBER_DATAWIDTH = 8,
    parameter int NUMBER_INPUTS    = 4,
    parameter int NUMBER_SHIFT     = 8
) (
    input  logic                        CC_NEURON_ACCUMULATOR_CLOCK_50,
    input  logic                        CC_NEURON_ACCUMULATOR_RESET_InHigh,
    input  logic                        CC_NEURON_ACCUMULATOR_start_In,
    input  logic [7:0]                  CC_NEURON_ACCUMULATOR_data_InBUS,
    input  logic [7:0]                  CC_NEURON_ACCUMULATOR_weight_InBUS,
    input  logic                        CC_NEURON_ACCUMULATOR_valid_In,
    output logic                        CC_NEURON_ACCUMULATOR_ready_Out,
    output logic                        CC_NEURON_ACCUMULATOR_busy_Out,
    output logic                        CC_NEURON_ACCUMULATOR_done_Out,
    output logic [NUMBER_DATAWIDTH-1:0] CC_NEURON_ACCUMULATOR_result_OutBUS
);

    localparam int ACC_W  = 16 + $clog2(NUMBER_INPUTS);
    localparam int CNT_W  = $clog2(NUMBER_INPUTS + 1);
    localparam int WIDE_W = ACC_W + NUMBER_DATAWIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMBER_INPUTS - 1);
    localparam logic [WIDE_W-1:0] SAT_MAX =
        {{ACC_W{1'b0}}, {NUMBER_DATAWIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} stateType;

    stateType                    state;
    logic [ACC_W-1:0]            accumSum;
    logic [CNT_W-1:0]            sampleCount;
    logic                        readyReg;
    logic                        busyReg;
    logic                        doneReg;
    logic [NUMBER_DATAWIDTH-1:0] resultReg;

    logic [15:0]                 product;
    logic [ACC_W-1:0]            sumNext;
    logic [WIDE_W-1:0]           scaledSum;
    logic [NUMBER_DATAWIDTH-1:0] satResult;
    logic                        accept;

    assign product = {8'd0, CC_NEURON_ACCUMULATOR_data_InBUS}
                   * {8'd0, CC_NEURON_ACCUMULATOR_weight_InBUS};
    assign sumNext   = accumSum + ACC_W'(product);
    assign scaledSum = WIDE_W'(sumNext >> NUMBER_SHIFT);
    // Clamp instead of truncating so a large sum never wraps to a small one
    assign satResult = (scaledSum > SAT_MAX) ? SAT_MAX[NUMBER_DATAWIDTH-1:0]
                                             : scaledSum[NUMBER_DATAWIDTH-1:0];
    assign accept = readyReg && CC_NEURON_ACCUMULATOR_valid_In;

    always_ff @(posedge CC_NEURON_ACCUMULATOR_CLOCK_50) begin
        if (CC_NEURON_ACCUMULATOR_RESET_InHigh) begin
            state       <= IDLE;
            accumSum    <= '0;
            sampleCount <= '0;
            readyReg    <= 1'b0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
            resultReg   <= '0;
        end else begin
            doneReg <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (CC_NEURON_ACCUMULATOR_start_In) begin
                        state       <= ACC;
                        accumSum    <= '0;
                        sampleCount <= '0;
                        readyReg    <= 1'b1;
                        busyReg     <= 1'b1;
                    end
                end
                ACC: begin
                    if (accept) begin
                        accumSum    <= sumNext;
                        sampleCount <= sampleCount + 1'b1;
                        // Result lands together with done, one cycle after the last pair
                        if (sampleCount == LAST_IDX) begin
                            state     <= DONE;
                            readyReg  <= 1'b0;
                            doneReg   <= 1'b1;
                            resultReg <= satResult;
                        end
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    readyReg <= 1'b0;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

    assign CC_NEURON_ACCUMULATOR_ready_Out     = readyReg;
    assign CC_NEURON_ACCUMULATOR_busy_Out      = busyReg;
    assign CC_NEURON_ACCUMULATOR_done_Out      = doneReg;
    assign CC_NEURON_ACCUMULATOR_result_OutBUS = resultReg;

endmodule

// File: doc/cc_neuron_accumulator.md
CC_NEURON_ACCUMULATOR -- requirements
Module: cc_neuron_accumulator

Interface
REQ-001 SHALL have parameter NUMBER_DATAWIDTH, default 8, width of the result bus driven into the downstream comparator c0 input.
REQ-002 SHALL have parameter NUMBER_INPUTS, default 4, number of synapse samples per neuron evaluation (range 2..16).
REQ-003 SHALL have parameter NUMBER_SHIFT, default 8, right-shift applied to the final sum before saturation.
REQ-004 SHALL have port CC_NEURON_ACCUMULATOR_CLOCK_50  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port CC_NEURON_ACCUMULATOR_RESET_InHigh  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port CC_NEURON_ACCUMULATOR_start_In  input  1  begin one evaluation; sampled only in IDLE.
REQ-007 SHALL have port CC_NEURON_ACCUMULATOR_data_InBUS  input  8  unsigned synapse input x.
REQ-008 SHALL have port CC_NEURON_ACCUMULATOR_weight_InBUS  input  8  unsigned synapse weight w.
REQ-009 SHALL have port CC_NEURON_ACCUMULATOR_valid_In  input  1  x/w pair present this cycle.
REQ-010 SHALL have port CC_NEURON_ACCUMULATOR_ready_Out  output  1  block accepts a pair this cycle.
REQ-011 SHALL have port CC_NEURON_ACCUMULATOR_busy_Out  output  1  evaluation in progress.
REQ-012 SHALL have port CC_NEURON_ACCUMULATOR_done_Out  output  1  one-cycle pulse, new result valid.
REQ-013 SHALL have port CC_NEURON_ACCUMULATOR_result_OutBUS  output  NUMBER_DATAWIDTH  saturated scaled weighted sum, registered.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, DONE; reset state IDLE.
REQ-015 IDLE: start_In=1 -> ACC next cycle, accumulator and sample counter cleared; start_In=0 -> stay.
REQ-016 ACC: ready_Out=1, busy_Out=1; pair accepted on a cycle with valid_In=1 and ready_Out=1.
REQ-017 Each accepted pair SHALL add the 16-bit unsigned product x*w to an accumulator of width 16+ceil(log2(NUMBER_INPUTS)), never overflowing.
REQ-018 valid_In=0 in ACC SHALL leave accumulator and counter unchanged (gaps allowed, no timeout).
REQ-019 On acceptance of the NUMBER_INPUTS-th pair -> DONE next cycle; counter SHALL NOT wrap past NUMBER_INPUTS.
REQ-020 DONE lasts exactly one cycle: done_Out=1, result_OutBUS updated that same cycle, then -> IDLE.
REQ-021 Result = (accumulator >> NUMBER_SHIFT), saturated to 2^NUMBER_DATAWIDTH-1 if larger (unsigned clamp, no wrap).
REQ-022 Latency: done_Out asserts the cycle after the last pair is accepted.
REQ-023 result_OutBUS SHALL hold its value in IDLE and ACC until the next DONE.
REQ-024 ready_Out=0 and busy_Out=0 in IDLE; ready_Out=0, busy_Out=1 in DONE.
REQ-025 start_In in ACC or DONE SHALL be ignored (no restart, no clear).
REQ-026 valid_In outside ACC SHALL be ignored; pairs are not buffered.
REQ-027 start_In asserted in the cycle DONE->IDLE is not accepted; it is accepted only if still high while in IDLE.

Reset
REQ-028 Reset SHALL take priority over all other inputs, in any state, including mid-ACC.
REQ-029 Cycle after reset: state IDLE, accumulator 0, counter 0, result_OutBUS 0, done_Out 0, ready_Out 0, busy_Out 0.
REQ-030 A partial evaluation interrupted by reset SHALL be discarded; no done_Out is produced for it.

Verification
REQ-031 Defaults; start, then 4 back-to-back pairs x=16,w=16 -> sum 1024, done_Out one cycle after 4th pair, result_OutBUS=4.
REQ-032 4 pairs x=255,w=255 -> sum 260100, >>8=1016, result_OutBUS saturates to 255.
REQ-033 Pairs (10,200),(0,0),(50,100),(255,1) with valid_In gaps of 0..3 cycles -> sum 7255, result 28; done only after 4th accepted pair.
REQ-034 Reset asserted after 2 accepted pairs -> next cycle IDLE, result_OutBUS=0, no done_Out; fresh run of 4x(16,16) gives 4.
REQ-035 start_In pulsed during ACC and valid_In pulsed in IDLE -> no restart, no extra accumulation; result unchanged from REQ-031 expectation.
REQ-036 Result of REQ-031 fed with threshold 3 to downstream comparator -> comparator output 1; threshold 4 -> 0.
